route_sequencer: RTL and testbench
==================================

// Module: route_sequencer
// PURPOSE
//  Upstream command stage for the servo driver. Buffers a queue of motion segments
//  (direction, duration in clk_26 ticks) and plays them back in order.
//  Drives the 2-bit dir code consumed by the servo PWM driver (00 stop, 01 fwd, 10 rev).
//  Replaces hard-coded location/move arithmetic with a loadable, flushable route.
// PARAMETERS
//  DUR_W      11  width of segment duration field (ticks of clk_26)
//  DEPTH      4   segment FIFO entries; power of 2, >=2
//  GAP_TICKS  2   stop cycles inserted between segments (SEG_GAP_EN only), >=1
// PORTS
//  clk_26     in   1                  sequencer clock (divided system clock)
//  rst        in   1                  reset, synchronous, active-high
//  cmd_valid  in   1                  segment write request
//  cmd_ready  out  1                  FIFO can accept; write occurs when valid&&ready
//  cmd_dir    in   2                  segment direction code
//  cmd_dur    in   DUR_W              segment duration in ticks
//  start      in   1                  begin playback (level-sampled; ignored when busy)
//  abort      in   1                  flush queue, stop immediately
//  dir        out  2                  registered direction to servo driver
//  busy       out  1                  high while not IDLE
//  seg_done   out  1                  one-cycle pulse on final tick of each segment
//  level      out  $clog2(DEPTH)+1    FIFO occupancy
// BEHAVIOUR
//  - Reset: dir=00, busy=0, seg_done=0, level=0, FIFO pointers 0, state IDLE.
//  - cmd_ready = (level<DEPTH) && !abort. No write when full, even if a pop occurs
//    in the same cycle. Write with cmd_dur==0 handshakes (ready honoured) but is
//    discarded; level unchanged.
//  - Simultaneous write and pop (not full): level unchanged; pointers wrap mod DEPTH.
//  - FSM states: IDLE, RUN, GAP (GAP exists only with SEG_GAP_EN).
//    IDLE: dir=00. On edge sampling start=1 and level!=0: pop head, dir<=head.dir,
//      remaining<=head.dur-1, -> RUN. start with level==0: no effect.
//    RUN: dir held. remaining>0: decrement. remaining==0 (final tick): seg_done=1;
//      if level!=0 pop next and load it on next edge (back-to-back, no stop cycle);
//      else -> IDLE, dir<=00 on next edge.
//    A segment of duration D drives its dir code for exactly D consecutive cycles.
//  - Writes during RUN are allowed and extend the route if they land before the
//    final tick of the current segment.
//  - abort (priority over start, writes, pops): next edge state IDLE, dir=00,
//    level=0, seg_done=0, pointers cleared. rst mid-operation behaves identically.
//  - busy = (state!=IDLE); dir, busy, seg_done are registered outputs.
//  - DUR_W counter arithmetic is unsigned; no overflow possible (loads dur-1, dur>=1).
// CONFIGURATION
//  SEG_GAP_EN defined: at final tick of a segment with level!=0, go to GAP for
//    exactly GAP_TICKS cycles with dir=00, busy=1, then pop next and -> RUN.
//    abort in GAP behaves as above. No gap after the last segment.
//  SEG_GAP_EN undefined: GAP state and its counter are not built; segments chain
//    back-to-back.
// TESTING
//  1 write (01,3),(10,2); start -> dir 01 x3, 10 x2, then 00; seg_done at ticks 3,5;
//    busy high 5 cycles.
//  2 write 4 segments without start -> level=4, cmd_ready=0; 5th write held until
//    start pops one.
//  3 (01,10) running, abort at tick 4 -> dir=00, busy=0, level=0 next cycle; no seg_done.
//  4 start with empty FIFO -> busy, dir stay 0; write (01,0) -> level stays 0.
//  5 SEG_GAP_EN, GAP_TICKS=2: (01,3),(10,2) -> dir 01 x3, 00 x2, 10 x2, 00.
//  6 rst asserted mid-RUN with level=2 -> all outputs reset values next cycle.

Source files
------------

// File: rtl/route_sequencer.sv
// route_sequencer: buffered motion-segment sequencer feeding the servo PWM driver.
// Segments (dir code, duration in clk_26 ticks) are queued in a small FIFO and
// played back in order; dir codes: 00 stop, 01 fwd, 10 rev.
// Optional build macro SEG_GAP_EN: inserts GAP_TICKS stop cycles between
// consecutive segments (never after the last one).
module route_sequencer #(
  parameter int unsigned DUR_W     = 11,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic                     clk_26,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_dir,
  input  logic [DUR_W-1:0]         cmd_dur,
  input  logic                     start,
  input  logic                     abort,
  output logic [1:0]               dir,
  output logic                     busy,
  output logic                     seg_done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Reject parameter sets the pointer arithmetic cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_TICKS < 1) begin : g_bad_cfg
    $error("route_sequencer: DEPTH must be a power of 2 >= 2 and GAP_TICKS >= 1");
  end

`ifdef SEG_GAP_EN
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif

  // ---------------------------------------------------------------------------
  // Segment FIFO
  // ---------------------------------------------------------------------------
  logic [1:0]       dir_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [1:0]       head_dir;
  logic [DUR_W-1:0] head_dur;
  logic             wr_fire;
  logic             store;
  logic             pop;

  assign cmd_ready = (level_q < FULL_LVL) && !abort;
  assign wr_fire   = cmd_valid && cmd_ready;
  // Zero-length segments complete the handshake but are never queued.
  assign store     = wr_fire && (cmd_dur != '0);
  assign head_dir  = dir_mem[rd_ptr];
  assign head_dur  = dur_mem[rd_ptr];
  assign level     = level_q;

  // Segment storage; no reset needed, occupancy tracks validity.
  always_ff @(posedge clk_26) begin
    if (store) begin
      dir_mem[wr_ptr] <= cmd_dir;
      dur_mem[wr_ptr] <= cmd_dur;
    end
  end

  // FIFO pointers and occupancy; abort flushes like reset.
  always_ff @(posedge clk_26) begin
    if (rst || abort) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({store, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Playback FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic             busy_q;
  logic             seg_done_q, seg_done_d;
  logic [DUR_W-1:0] rem_q, rem_d;
`ifdef SEG_GAP_EN
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  assign dir      = dir_q;
  assign busy     = busy_q;
  assign seg_done = seg_done_q;

  // State and registered outputs.
  always_ff @(posedge clk_26) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= '0;
      busy_q     <= 1'b0;
      seg_done_q <= 1'b0;
      rem_q      <= '0;
`ifdef SEG_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      busy_q     <= (state_d != IDLE);
      seg_done_q <= seg_done_d;
      rem_q      <= rem_d;
`ifdef SEG_GAP_EN
      gap_q      <= gap_d;
`endif
    end
  end

  // Next state, segment loading and pop requests. seg_done is computed one
  // edge early so the registered pulse lands on the cycle where rem_q==0.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    rem_d      = rem_q;
    seg_done_d = 1'b0;
    pop        = 1'b0;
`ifdef SEG_GAP_EN
    gap_d      = gap_q;
`endif
    if (abort) begin
      state_d = IDLE;
      dir_d   = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          dir_d = '0;
          if (start && (level_q != '0)) begin
            pop        = 1'b1;
            state_d    = RUN;
            dir_d      = head_dir;
            rem_d      = head_dur - 1'b1;
            seg_done_d = (head_dur == DUR_W'(1));
          end
        end
        RUN: begin
          if (rem_q != '0) begin
            rem_d      = rem_q - 1'b1;
            seg_done_d = (rem_q == DUR_W'(1));
          end else if (level_q != '0) begin
`ifdef SEG_GAP_EN
            state_d = GAP;
            dir_d   = '0;
            gap_d   = GAP_W'(GAP_TICKS - 1);
`else
            pop        = 1'b1;
            dir_d      = head_dir;
            rem_d      = head_dur - 1'b1;
            seg_done_d = (head_dur == DUR_W'(1));
`endif
          end else begin
            state_d = IDLE;
            dir_d   = '0;
          end
        end
`ifdef SEG_GAP_EN
        GAP: begin
          dir_d = '0;
          if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
          end else begin
            // Nothing else pops while in GAP, so the head is still valid.
            pop        = 1'b1;
            state_d    = RUN;
            dir_d      = head_dir;
            rem_d      = head_dur - 1'b1;
            seg_done_d = (head_dur == DUR_W'(1));
          end
        end
`endif
        default: begin
          state_d = IDLE;
          dir_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_route_sequencer.sv
// Testbench for route_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a schedule-based model.
module tb_route_sequencer;

  localparam int DUR_W     = 11;
  localparam int DEPTH     = 4;
  localparam int GAP_TICKS = 2;

  logic             clk_26 = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_dir = '0;
  logic [DUR_W-1:0] cmd_dur = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       dir;
  logic             busy;
  logic             seg_done;
  logic [2:0]       level;

  int checks = 0;
  int failures = 0;

  route_sequencer #(.DUR_W(DUR_W), .DEPTH(DEPTH), .GAP_TICKS(GAP_TICKS)) dut (
    .clk_26(clk_26), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_dur(cmd_dur), .start(start), .abort(abort),
    .dir(dir), .busy(busy), .seg_done(seg_done), .level(level)
  );

  always #5 clk_26 = ~clk_26;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the queued segments plus a timeline of upcoming output
  // cycles. Empty timeline means idle.
  // ---------------------------------------------------------------------------
  typedef struct packed {logic [1:0] d; logic done; logic bsy; logic pop_after;} slot_t;
  typedef struct packed {logic [1:0] d; logic [DUR_W-1:0] dur;} seg_t;
  slot_t sched[$];
  seg_t  q[$];
  slot_t cur;
  seg_t  s;
  bit    do_pop, wr_ok;
  int    e_dir, e_done, e_busy;

  initial begin
    @(posedge clk_26);
    forever begin
      @(negedge clk_26);
      e_dir = 0; e_done = 0; e_busy = 0;
      if (sched.size() > 0) begin
        e_dir = sched[0].d; e_done = sched[0].done; e_busy = sched[0].bsy;
      end
      chk("m_dir", dir, e_dir);
      chk("m_busy", busy, e_busy);
      chk("m_seg_done", seg_done, e_done);
      chk("m_level", level, q.size());
      chk("m_cmd_ready", cmd_ready, (q.size() < DEPTH) && !abort);
      // Advance the model across the coming edge using the current inputs.
      if (rst || abort) begin
        q.delete();
        sched.delete();
      end else begin
        do_pop = 0;
        wr_ok = cmd_valid && (q.size() < DEPTH);
        if (sched.size() == 0) begin
          if (start && q.size() > 0) do_pop = 1;
        end else begin
          cur = sched.pop_front();
          if (cur.pop_after) do_pop = 1;
          else if (cur.done && q.size() > 0) begin
`ifdef SEG_GAP_EN
            for (int g = 0; g < GAP_TICKS; g++)
              sched.push_back('{d: 2'b00, done: 1'b0, bsy: 1'b1, pop_after: (g == GAP_TICKS - 1)});
`else
            do_pop = 1;
`endif
          end
        end
        if (do_pop) begin
          s = q.pop_front();
          for (int k = 0; k < int'(s.dur); k++)
            sched.push_back('{d: s.d, done: (k == int'(s.dur) - 1), bsy: 1'b1, pop_after: 1'b0});
        end
        if (wr_ok && cmd_dur != 0) q.push_back('{d: cmd_dir, dur: cmd_dur});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_26); #1; end
  endtask

  task automatic wr(input logic [1:0] d, input logic [DUR_W-1:0] u);
    cmd_valid = 1'b1; cmd_dir = d; cmd_dur = u;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_26);
      if (cmd_ready) begin
        @(posedge clk_26); #1;
        cmd_valid = 1'b0;
        return;
      end
    end
    chk("wr_timeout", 0, 1);
    @(posedge clk_26); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (!busy) return;
      tick(1);
    end
    chk("idle_timeout", busy, 0);
  endtask

  logic [1:0] t1_dir  [8];
  logic       t1_done [8];
  logic       t1_busy [8];

  initial begin
    tick(3);
    rst = 1'b0;
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seg_done", seg_done, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", cmd_ready, 1);

    // Two segments played back to back (or with a gap).
`ifdef SEG_GAP_EN
    t1_dir  = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
    t1_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    t1_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    t1_dir  = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
    t1_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    t1_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    wr(2'b01, 3);
    wr(2'b10, 2);
    chk("t1_level", level, 2);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_dir[%0d]", i), dir, t1_dir[i]);
      chk($sformatf("t1_done[%0d]", i), seg_done, t1_done[i]);
      chk($sformatf("t1_busy[%0d]", i), busy, t1_busy[i]);
      tick(1);
    end

    // Full FIFO holds off a fifth write until playback pops one.
    for (int i = 0; i < 4; i++) wr(2'b01, 5);
    chk("t2_level_full", level, 4);
    chk("t2_ready_full", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_dir = 2'b10; cmd_dur = 2;
    tick(2);
    chk("t2_level_held", level, 4);
    pulse_start();
    chk("t2_level_popped", level, 3);
    tick(1);
    cmd_valid = 1'b0;
    chk("t2_level_refill", level, 4);
    wait_idle(200);
    tick(2);

    // Abort mid-segment flushes everything on the next edge.
    wr(2'b01, 10);
    wr(2'b10, 3);
    pulse_start();
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t3_dir", dir, 0);
    chk("t3_busy", busy, 0);
    chk("t3_level", level, 0);
    chk("t3_seg_done", seg_done, 0);

    // Start with nothing queued; zero-length write is dropped.
    pulse_start();
    chk("t4_busy", busy, 0);
    chk("t4_dir", dir, 0);
    wr(2'b01, 0);
    chk("t4_level", level, 0);
    tick(1);
    chk("t4_busy2", busy, 0);

    // Reset during playback with two segments still queued.
    wr(2'b01, 6);
    wr(2'b10, 6);
    wr(2'b01, 6);
    pulse_start();
    chk("t6_level_pre", level, 2);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_dir", dir, 0);
    chk("t6_busy", busy, 0);
    chk("t6_seg_done", seg_done, 0);
    chk("t6_level", level, 0);
    chk("t6_ready", cmd_ready, 1);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_dir   = 2'($urandom_range(0, 3));
      cmd_dur   = DUR_W'($urandom_range(0, 7));
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 255) == 0);
      tick(1);
    end
    cmd_valid = 1'b0; start = 1'b0; abort = 1'b0; rst = 1'b0;
    tick(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
